// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one SRAM-like memory port between instruction fetch and
//            data load/store. One requester is granted at a time, using
//            round-robin when both ask together. The two-phase handshake
//            (address accept, then data return) runs on the shared port.
//            Read data and a one-cycle ok pulse go back to the winner, and a
//            pipeline stall is driven while either request is outstanding.
// Ports    : clk, rst (async, active-low)
//            i_req/i_addr      -> i_rdata/i_ok   fetch requester
//            d_req/d_wr/d_wstrb/d_addr/d_wdata -> d_rdata/d_ok  data requester
//            m_req/m_wr/m_wstrb/m_addr/m_wdata <- m_addr_ok/m_data_ok/m_rdata
//            stall             pipeline stall
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ok,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ok,
    output logic                m_req,
    output logic                m_wr,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_INST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_wstrb      = '0;
        m_addr       = '0;
        m_wdata      = '0;
        i_ok         = 1'b0;
        d_ok         = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;

        case (state_q)
            ST_IDLE: begin
                // Data wins a tie only if fetch had the previous grant.
                if (d_req && (!i_req || last_grant_q == GRANT_INST)) begin
                    state_d      = ST_D_ADDR;
                    last_grant_d = GRANT_DATA;
                end else if (i_req) begin
                    state_d      = ST_I_ADDR;
                    last_grant_d = GRANT_INST;
                end
            end
            ST_I_ADDR: begin
                // Requesters hold their inputs until ok, so passing them
                // straight through keeps m_* stable across wait states.
                m_req  = 1'b1;
                m_addr = i_addr;
                if (m_addr_ok) begin
                    state_d = ST_I_DATA;
                end
            end
            ST_D_ADDR: begin
                m_req   = 1'b1;
                m_wr    = d_wr;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wr ? d_wstrb : '0;
                if (m_addr_ok) begin
                    state_d = ST_D_DATA;
                end
            end
            ST_I_DATA: begin
                if (m_data_ok) begin
                    i_ok    = 1'b1;
                    i_rdata = m_rdata;
                    state_d = ST_IDLE;
                end
            end
            ST_D_DATA: begin
                if (m_data_ok) begin
                    d_ok    = 1'b1;
                    d_rdata = m_rdata;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stall = (i_req & ~i_ok) | (d_req & ~d_ok);

endmodule
`default_nettype wire
